bcd_serial_add_ctrl: RTL and testbench

- Sequences the team's single-digit combinational BCD adder (A, B, Cin -> Sum, Cout) to add two DIGITS-wide packed-BCD operands, one digit per clock, least-significant digit first.
- The adder stays outside this block: the controller drives its inputs, consumes its outputs, keeps the ripple carry in a register, and assembles the multi-digit result.
- Start/done handshake toward a host: a testbench, or later a multi-digit BCD arithmetic unit.

---
 rtl/bcd_serial_add_ctrl_pkg.sv | 18 +
 rtl/bcd_serial_add_ctrl.sv | 133 +++++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_serial_add_ctrl_pkg.sv
// Shared definitions for the digit-serial BCD add controller: state encoding,
// BCD digit limits and a digit-validity helper.
package bcd_serial_add_ctrl_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
        return d > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder controller: feeds an external single-digit BCD adder
// one digit per clock (LSD first), ripples the carry and assembles the result.
module bcd_serial_add_ctrl
    import bcd_serial_add_ctrl_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [4*DIGITS-1:0]     a_bcd,
    input  logic [4*DIGITS-1:0]     b_bcd,
    input  logic                    cin,
    output logic                    busy,
    output logic                    done,
    output logic [4*DIGITS-1:0]     sum_bcd,
    output logic                    cout,
    output logic                    err,
    output logic [3:0]              add_a,
    output logic [3:0]              add_b,
    output logic                    add_cin,
    input  logic [3:0]              add_sum,
    input  logic                    add_cout
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_e               state_q;
    logic [DIGIT_W-1:0]   a_dig_q   [DIGITS];
    logic [DIGIT_W-1:0]   b_dig_q   [DIGITS];
    logic [DIGIT_W-1:0]   sum_dig_q [DIGITS];
    logic [IDX_W-1:0]     idx_q;
    logic                 carry_q;
    logic                 cout_q;
    logic                 err_q;

    logic [DIGITS-1:0]    a_bad;
    logic [DIGITS-1:0]    b_bad;
    logic                 operand_bad;
    logic [DIGITS-1:0]    idx_sel;
    logic [DIGIT_W-1:0]   cur_a;
    logic [DIGIT_W-1:0]   cur_b;
    logic                 accept;
    logic                 running;

    // Per-digit decode: validity of incoming operands, one-hot digit select,
    // and unpacking of the result digits onto the output bus.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign a_bad[gi]   = digit_invalid(a_bcd[gi*DIGIT_W +: DIGIT_W]);
            assign b_bad[gi]   = digit_invalid(b_bcd[gi*DIGIT_W +: DIGIT_W]);
            assign idx_sel[gi] = (idx_q == IDX_W'(gi));
            assign sum_bcd[gi*DIGIT_W +: DIGIT_W] = sum_dig_q[gi];
        end
    endgenerate

    assign operand_bad = (|a_bad) | (|b_bad);

    always_comb begin
        cur_a = '0;
        cur_b = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_sel[i]) begin
                cur_a = a_dig_q[i];
                cur_b = b_dig_q[i];
            end
        end
    end

    assign running = (state_q == ST_RUN);
    assign accept  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    assign busy    = running;
    assign done    = (state_q == ST_DONE);
    assign cout    = cout_q;
    assign err     = err_q;
    assign add_a   = running ? cur_a : '0;
    assign add_b   = running ? cur_b : '0;
    assign add_cin = running ? carry_q : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                a_dig_q[i]   <= '0;
                b_dig_q[i]   <= '0;
                sum_dig_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        for (int i = 0; i < DIGITS; i++) begin
                            a_dig_q[i]   <= a_bcd[i*DIGIT_W +: DIGIT_W];
                            b_dig_q[i]   <= b_bcd[i*DIGIT_W +: DIGIT_W];
                            sum_dig_q[i] <= '0;
                        end
                        carry_q <= cin;
                        idx_q   <= '0;
                        err_q   <= operand_bad;
                        cout_q  <= 1'b0;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (idx_sel[i]) begin
                            sum_dig_q[i] <= add_sum;
                        end
                    end
                    carry_q <= add_cout;
                    // Index returns to 0 after the top digit so DIGITS=1 never leaves 0.
                    if (idx_q == LAST_IDX) begin
                        cout_q  <= add_cout;
                        idx_q   <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Scoreboard bench for bcd_serial_add_ctrl with a behavioural single-digit BCD adder.
module tb_bcd_serial_add_ctrl;

    localparam int D = 4;
    localparam int W = 4 * D;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_bcd = '0;
    logic [W-1:0] b_bcd = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout, err;
    logic [W-1:0] sum_bcd;
    logic [3:0]   add_a, add_b, add_sum;
    logic         add_cin, add_cout;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
        int           done_cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   busy_cnt = 0;

    bcd_serial_add_ctrl #(.DIGITS(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_bcd(a_bcd), .b_bcd(b_bcd), .cin(cin),
        .busy(busy), .done(done), .sum_bcd(sum_bcd), .cout(cout), .err(err),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-digit BCD adder: binary add, then +6 correction above 9.
    logic [5:0] raw_s, cor_s;
    always_comb begin
        raw_s = 6'(add_a) + 6'(add_b) + 6'(add_cin);
        cor_s = raw_s + 6'd6;
        if (raw_s > 6'd9) begin
            add_sum  = cor_s[3:0];
            add_cout = 1'b1;
        end else begin
            add_sum  = raw_s[3:0];
            add_cout = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Decimal reference over the low 'upto' digits; c ends as carry into digit 'upto'.
    function automatic void bcd_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic ci, input int upto,
                                    output logic [W-1:0] s, output logic c);
        int t;
        c = ci;
        s = '0;
        for (int i = 0; i < upto; i++) begin
            t = int'(a[i*4 +: 4]) + int'(b[i*4 +: 4]) + int'(c);
            if (t >= 10) begin
                s[i*4 +: 4] = 4'(t - 10);
                c = 1'b1;
            end else begin
                s[i*4 +: 4] = 4'(t);
                c = 1'b0;
            end
        end
    endfunction

    function automatic logic any_bad(input logic [W-1:0] a, input logic [W-1:0] b);
        logic bad = 1'b0;
        for (int i = 0; i < D; i++) begin
            if (a[i*4 +: 4] > 4'd9 || b[i*4 +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Drive a start for one cycle and queue the expected result.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        exp_t e;
        a_bcd = a;
        b_bcd = b;
        cin   = ci;
        start = 1'b1;
        e.a = a;
        e.b = b;
        e.cin = ci;
        bcd_ref(a, b, ci, D, e.sum, e.cout);
        e.err = any_bad(a, b);
        e.done_cyc = cyc + D + 1;
        q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        wait_idle();
        issue(a, b, ci);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_timeout", 32'(done), 32'd1);
    endtask

    // Monitor: per-digit adder drive checks while busy, scoreboard pop on done.
    always @(negedge clk) begin
        logic [W-1:0] s_tmp;
        logic         c_in;
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) begin
                if (q.size() == 0) begin
                    chk("busy_no_op", 32'(busy), 32'd0);
                end else begin
                    chk("add_a", 32'(add_a), 32'(q[0].a[busy_cnt*4 +: 4]));
                    chk("add_b", 32'(add_b), 32'(q[0].b[busy_cnt*4 +: 4]));
                    if (!q[0].err) begin
                        bcd_ref(q[0].a, q[0].b, q[0].cin, busy_cnt, s_tmp, c_in);
                        chk("add_cin", 32'(add_cin), 32'(c_in));
                    end
                end
                busy_cnt = busy_cnt + 1;
            end else begin
                chk("add_idle", 32'({add_a, add_b, add_cin}), 32'd0);
            end
            if (done) begin
                if (q.size() == 0) begin
                    chk("done_unexp", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    $display("txn %h + %h + %0d -> sum=%h cout=%0d err=%0d cyc=%0d",
                             e.a, e.b, e.cin, sum_bcd, cout, err, cyc);
                    chk("busy_len", 32'(busy_cnt), 32'(D));
                    chk("done_cyc", 32'(cyc), 32'(e.done_cyc));
                    chk("err", 32'(err), 32'(e.err));
                    if (!e.err) begin
                        chk("sum", 32'(sum_bcd), 32'(e.sum));
                        chk("cout", 32'(cout), 32'(e.cout));
                    end
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        int n;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum_bcd), 32'd0);
        chk("rst_flags", 32'({cout, err}), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(16'h1234, 16'h5678, 1'b0);
        chk("busy_run", 32'(busy), 32'd1);
        run_op(16'h9999, 16'h0001, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1);
        run_op(16'h9999, 16'h9999, 1'b1);

        run_op(16'h12A4, 16'h0000, 1'b0);
        chk("err_accept", 32'(err), 32'd1);
        run_op(16'h4321, 16'h0000, 1'b0);
        chk("err_clear", 32'(err), 32'd0);

        // Start re-pulsed mid-run must be ignored.
        run_op(16'h1234, 16'h5678, 1'b0);
        @(posedge clk); #1;
        a_bcd = 16'h1111;
        b_bcd = 16'h1111;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        // Back-to-back: start while done is high.
        wait_done();
        issue(16'h0987, 16'h0013, 1'b0);
        wait_done();
        issue(16'h5000, 16'h4999, 1'b1);

        // Asynchronous reset mid-run.
        run_op(16'h1234, 16'h5678, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_sum", 32'(sum_bcd), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(16'h0500, 16'h0500, 1'b0);
        wait_done();
        repeat (3) @(posedge clk);
        #1;
        chk("sum_hold", 32'(sum_bcd), 32'h1000);
        chk("cout_hold", 32'(cout), 32'd0);

        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("q_drain", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
